// File: rtl/bch_31_chien_corrector.sv
// Serial Chien search and bit corrector for the t=2 BCH(31) decoder.
// Evaluates 1 + lambda1*x + lambda2*x^2 at x = alpha^i, one element per clock, and flips located bits.
module bch_31_chien_corrector #(
  parameter int         N         = 31,
  parameter logic [4:0] PRIM_POLY = 5'b00101
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   lambda1,
  input  logic [4:0]   lambda2,
  input  logic [N-1:0] rx_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic [1:0]   err_count,
  output logic         uncorrectable
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [4:0] LAST_STEP = 5'(N - 1);

  logic [1:0]   state;
  logic [N-1:0] work_word;
  logic [N-1:0] rx_latch;
  logic [4:0]   r1;
  logic [4:0]   r2;
  logic [4:0]   step;
  logic [1:0]   roots;
  logic [1:0]   exp_deg;

  logic [4:0]   sum;
  logic         hit;
  logic [4:0]   pos;
  logic [N-1:0] flip_mask;
  logic [N-1:0] word_step;
  logic [1:0]   roots_step;
  logic [1:0]   count_sat;
  logic         match;

  function automatic logic [4:0] mul_alpha(input logic [4:0] a);
    return {a[3:0], 1'b0} ^ (a[4] ? PRIM_POLY : 5'b00000);
  endfunction

  // A root at alpha^i marks error position -i mod 31, so step 0 maps to bit 0.
  always_comb begin
    sum        = 5'b00001 ^ r1 ^ r2;
    hit        = (sum == 5'd0);
    pos        = (step == 5'd0) ? 5'd0 : (5'(N) - step);
    flip_mask  = {{(N-1){1'b0}}, 1'b1} << pos;
    word_step  = hit ? (work_word ^ flip_mask) : work_word;
    roots_step = (hit && (roots != 2'd3)) ? (roots + 2'd1) : roots;
    count_sat  = (roots_step == 2'd3) ? 2'd2 : roots_step;
    match      = (roots_step == exp_deg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      data_out      <= '0;
      err_count     <= 2'd0;
      uncorrectable <= 1'b0;
      work_word     <= '0;
      rx_latch      <= '0;
      r1            <= 5'd0;
      r2            <= 5'd0;
      step          <= 5'd0;
      roots         <= 2'd0;
      exp_deg       <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            work_word <= rx_word;
            rx_latch  <= rx_word;
            r1        <= lambda1;
            r2        <= lambda2;
            step      <= 5'd0;
            roots     <= 2'd0;
            exp_deg   <= (lambda2 != 5'd0) ? 2'd2 :
                         (lambda1 != 5'd0) ? 2'd1 : 2'd0;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          work_word <= word_step;
          roots     <= roots_step;
          r1        <= mul_alpha(r1);
          r2        <= mul_alpha(mul_alpha(r2));
          step      <= step + 5'd1;
          // The final step's root must be folded into the result registered here.
          if (step == LAST_STEP) begin
            state         <= DONE;
            out_valid     <= 1'b1;
            data_out      <= match ? word_step : rx_latch;
            err_count     <= count_sat;
            uncorrectable <= !match;
          end
        end
        DONE: begin
          if (out_ready) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            data_out      <= '0;
            err_count     <= 2'd0;
            uncorrectable <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_31_chien_corrector.sv
// Self-checking bench for bch_31_chien_corrector: directed and randomized jobs checked
// against a GF(2^5) polynomial-evaluation reference model.
module tb_bch_31_chien_corrector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  lambda1 = 5'd0;
  logic [4:0]  lambda2 = 5'd0;
  logic [30:0] rx_word = 31'd0;
  logic        in_ready;
  logic        out_valid;
  logic [30:0] data_out;
  logic [1:0]  err_count;
  logic        uncorrectable;

  int checks = 0;
  int errors = 0;
  logic [4:0] alpha_tab [31];

  bch_31_chien_corrector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lambda1(lambda1), .lambda2(lambda2), .rx_word(rx_word),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .err_count(err_count), .uncorrectable(uncorrectable)
  );

  always #5 clk = ~clk;

  // Schoolbook carry-less product, then reduction modulo x^5+x^2+1.
  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [8:0] p;
    p = 9'd0;
    for (int k = 0; k < 5; k++) if (b[k]) p = p ^ (9'(a) << k);
    for (int d = 8; d >= 5; d--) if (p[d]) p = p ^ (9'b000100101 << (d - 5));
    return p[4:0];
  endfunction

  function automatic void model(input logic [4:0] l1, input logic [4:0] l2, input logic [30:0] rx,
                                output logic [30:0] d, output logic [1:0] c, output logic u);
    int          nroots;
    int          expd;
    logic [30:0] corr;
    logic [4:0]  x;
    logic [4:0]  v;
    nroots = 0;
    corr   = rx;
    for (int i = 0; i < 31; i++) begin
      x = alpha_tab[i];
      v = 5'd1 ^ gf_mul(l1, x) ^ gf_mul(l2, gf_mul(x, x));
      if (v == 5'd0) begin
        nroots++;
        corr[(31 - i) % 31] = ~corr[(31 - i) % 31];
      end
    end
    expd = (l2 != 5'd0) ? 2 : ((l1 != 5'd0) ? 1 : 0);
    d = (nroots == expd) ? corr : rx;
    c = (nroots > 2) ? 2'd2 : 2'(nroots);
    u = (nroots != expd);
  endfunction

  function automatic void make_job(input int mode, output logic [4:0] l1, output logic [4:0] l2,
                                   output logic [30:0] rx);
    int j1;
    int j2;
    rx = 31'($urandom);
    l1 = 5'd0;
    l2 = 5'd0;
    if (mode == 0) begin
      l1 = 5'($urandom);
      l2 = 5'($urandom);
    end else if (mode == 1) begin
      l1 = alpha_tab[$urandom_range(0, 30)];
    end else if (mode == 2) begin
      j1 = $urandom_range(0, 30);
      j2 = $urandom_range(0, 30);
      while (j2 == j1) j2 = $urandom_range(0, 30);
      l1 = alpha_tab[j1] ^ alpha_tab[j2];
      l2 = gf_mul(alpha_tab[j1], alpha_tab[j2]);
    end
  endfunction

  // Waits for in_ready, submits a job, scrambles the inputs, and counts cycles to out_valid.
  task automatic start_job(input logic [4:0] l1, input logic [4:0] l2, input logic [30:0] rx,
                           output int cycles);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    lambda1  = l1;
    lambda2  = l2;
    rx_word  = rx;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lambda1  = 5'($urandom);
    lambda2  = 5'($urandom);
    rx_word  = 31'($urandom);
    cycles   = 0;
    while (!out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    if (data_out !== 31'd0) begin errors++; $display("[TB] FAIL reset_data_out: got %h want 0", data_out); end
    if (err_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_err_count: got %0d want 0", err_count); end
    if (uncorrectable !== 1'b0) begin errors++; $display("[TB] FAIL reset_uncorrectable: got %b want 0", uncorrectable); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [4:0]  dl1 [4] = '{5'b00000, 5'b00101, 5'b01001, 5'b00000};
    logic [4:0]  dl2 [4] = '{5'b00000, 5'b00000, 5'b01000, 5'b00001};
    logic [30:0] drx [4] = '{31'h1234_5678, 31'h0000_0020, 31'h0000_0009, 31'h7FFF_FFFF};
    logic [30:0] dd  [4] = '{31'h1234_5678, 31'h0000_0000, 31'h0000_0000, 31'h7FFF_FFFF};
    logic [1:0]  dc  [4] = '{2'd0, 2'd1, 2'd2, 2'd1};
    logic        du  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int cycles;
    for (int t = 0; t < 4; t++) begin
      start_job(dl1[t], dl2[t], drx[t], cycles);
      checks += 5;
      if (cycles !== 31) begin errors++; $display("[TB] FAIL directed%0d_latency: got %0d want 31", t, cycles); end
      if (data_out !== dd[t]) begin errors++; $display("[TB] FAIL directed%0d_data: got %h want %h", t, data_out, dd[t]); end
      if (err_count !== dc[t]) begin errors++; $display("[TB] FAIL directed%0d_count: got %0d want %0d", t, err_count, dc[t]); end
      if (uncorrectable !== du[t]) begin errors++; $display("[TB] FAIL directed%0d_uncorr: got %b want %b", t, uncorrectable, du[t]); end
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL directed%0d_in_ready: got %b want 0", t, in_ready); end
      accept_result();
    end
  endtask

  task automatic test_random();
    logic [4:0]  l1;
    logic [4:0]  l2;
    logic [30:0] rx;
    logic [30:0] ed;
    logic [1:0]  ec;
    logic        eu;
    int cycles;
    for (int n = 0; n < 40; n++) begin
      make_job(n % 4, l1, l2, rx);
      model(l1, l2, rx, ed, ec, eu);
      start_job(l1, l2, rx, cycles);
      checks += 4;
      if (cycles !== 31) begin errors++; $display("[TB] FAIL random%0d_latency: got %0d want 31", n, cycles); end
      if (data_out !== ed) begin errors++; $display("[TB] FAIL random%0d_data: got %h want %h", n, data_out, ed); end
      if (err_count !== ec) begin errors++; $display("[TB] FAIL random%0d_count: got %0d want %0d", n, err_count, ec); end
      if (uncorrectable !== eu) begin errors++; $display("[TB] FAIL random%0d_uncorr: got %b want %b", n, uncorrectable, eu); end
      accept_result();
    end
  endtask

  task automatic test_backpressure();
    logic [4:0]  l1;
    logic [4:0]  l2;
    logic [30:0] rx;
    logic [30:0] ed;
    logic [1:0]  ec;
    logic        eu;
    int cycles;
    make_job(2, l1, l2, rx);
    model(l1, l2, rx, ed, ec, eu);
    start_job(l1, l2, rx, cycles);
    checks++;
    if (cycles !== 31) begin errors++; $display("[TB] FAIL bp_latency: got %0d want 31", cycles); end
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid%0d: got %b want 1", k, out_valid); end
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_in_ready%0d: got %b want 0", k, in_ready); end
      if (data_out !== ed) begin errors++; $display("[TB] FAIL bp_hold_data%0d: got %h want %h", k, data_out, ed); end
      if ({err_count, uncorrectable} !== {ec, eu}) begin
        errors++; $display("[TB] FAIL bp_hold_status%0d: got %0d/%b want %0d/%b", k, err_count, uncorrectable, ec, eu);
      end
    end
    in_valid = 1'b0;
    accept_result();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_ready: got %b want 1", in_ready); end
    make_job(1, l1, l2, rx);
    model(l1, l2, rx, ed, ec, eu);
    start_job(l1, l2, rx, cycles);
    checks += 3;
    if (cycles !== 31) begin errors++; $display("[TB] FAIL bp_second_latency: got %0d want 31", cycles); end
    if (data_out !== ed) begin errors++; $display("[TB] FAIL bp_second_data: got %h want %h", data_out, ed); end
    if ({err_count, uncorrectable} !== {ec, eu}) begin
      errors++; $display("[TB] FAIL bp_second_status: got %0d/%b want %0d/%b", err_count, uncorrectable, ec, eu);
    end
    accept_result();
  endtask

  task automatic test_async_reset();
    logic [4:0]  l1;
    logic [4:0]  l2;
    logic [30:0] rx;
    logic [30:0] ed;
    logic [1:0]  ec;
    logic        eu;
    int waitc;
    int cycles;
    make_job(2, l1, l2, rx);
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 100) begin @(negedge clk); waitc++; end
    lambda1 = l1; lambda2 = l2; rx_word = rx; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if ({out_valid, data_out, err_count, uncorrectable} !== 35'd0) begin
      errors++; $display("[TB] FAIL rst_search_outputs: got %b/%h/%0d/%b want zeros", out_valid, data_out, err_count, uncorrectable);
    end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_search_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    rx = rx | 31'h1;
    start_job(l1, l2, rx, cycles);
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_done_valid: got %b want 0", out_valid); end
    if (data_out !== 31'd0) begin errors++; $display("[TB] FAIL rst_done_data: got %h want 0", data_out); end
    if (err_count !== 2'd0) begin errors++; $display("[TB] FAIL rst_done_count: got %0d want 0", err_count); end
    if (uncorrectable !== 1'b0) begin errors++; $display("[TB] FAIL rst_done_uncorr: got %b want 0", uncorrectable); end
    @(negedge clk);
    rst = 1'b0;
    make_job(2, l1, l2, rx);
    model(l1, l2, rx, ed, ec, eu);
    start_job(l1, l2, rx, cycles);
    checks += 3;
    if (cycles !== 31) begin errors++; $display("[TB] FAIL rst_fresh_latency: got %0d want 31", cycles); end
    if (data_out !== ed) begin errors++; $display("[TB] FAIL rst_fresh_data: got %h want %h", data_out, ed); end
    if ({err_count, uncorrectable} !== {ec, eu}) begin
      errors++; $display("[TB] FAIL rst_fresh_status: got %0d/%b want %0d/%b", err_count, uncorrectable, ec, eu);
    end
    accept_result();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  l1;
    logic [4:0]  l2;
    logic [30:0] rx;
    logic [30:0] ed;
    logic [1:0]  ec;
    logic        eu;
    int cycles;
    make_job(1, l1, l2, rx);
    start_job(l1, l2, rx, cycles);
    make_job(2, l1, l2, rx);
    model(l1, l2, rx, ed, ec, eu);
    lambda1 = l1; lambda2 = l2; rx_word = rx;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_not_taken_in_done: got in_ready %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_handoff_valid: got %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    rx_word  = 31'($urandom);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept_in_ready: got %b want 0", in_ready); end
    cycles = 0;
    while (!out_valid && cycles < 100) begin @(negedge clk); cycles++; end
    checks += 3;
    if (cycles !== 31) begin errors++; $display("[TB] FAIL b2b_latency: got %0d want 31", cycles); end
    if (data_out !== ed) begin errors++; $display("[TB] FAIL b2b_data: got %h want %h", data_out, ed); end
    if ({err_count, uncorrectable} !== {ec, eu}) begin
      errors++; $display("[TB] FAIL b2b_status: got %0d/%b want %0d/%b", err_count, uncorrectable, ec, eu);
    end
    accept_result();
  endtask

  initial begin
    alpha_tab[0] = 5'd1;
    for (int k = 1; k < 31; k++) alpha_tab[k] = gf_mul(alpha_tab[k-1], 5'd2);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
